// File: rtl/bridge_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM encoding and
// default parameter values.
package bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  localparam int ADDR_WIDTH_DEF = 36;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int TIMEOUT_DEF    = 255;

endpackage

// File: rtl/wb_arbiter_2.sv
// Two-master Wishbone arbiter (m0 = LIMB, m1 = CPU) with round-robin tie break
// and per-strobe ack timeout; ownership always passes through IDLE.
module wb_arbiter_2
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
  input  logic [DATA_WIDTH-1:0]   m0_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
  input  logic                    m0_we_i,
  input  logic                    m0_stb_i,
  input  logic                    m0_cyc_i,
  output logic [DATA_WIDTH-1:0]   m0_dat_o,
  output logic                    m0_ack_o,
  output logic                    m0_err_o,
  input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
  input  logic [DATA_WIDTH-1:0]   m1_dat_i,
  input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
  input  logic                    m1_we_i,
  input  logic                    m1_stb_i,
  input  logic                    m1_cyc_i,
  output logic [DATA_WIDTH-1:0]   m1_dat_o,
  output logic                    m1_ack_o,
  output logic                    m1_err_o,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic [DATA_WIDTH/8-1:0] s_sel_o,
  output logic                    s_we_o,
  output logic                    s_stb_o,
  output logic                    s_cyc_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  input  logic                    s_ack_i,
  output logic [1:0]              gnt_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic own0, own1, owner_stb, timeout_hit;

  // Ownership is masked while rst is high so the bus goes quiet in the very
  // cycle reset is raised, not only after the edge.
  assign own0 = ~rst & (state_q == ST_OWN0);
  assign own1 = ~rst & (state_q == ST_OWN1);
  assign owner_stb   = (own0 & m0_stb_i) | (own1 & m1_stb_i);
  assign timeout_hit = owner_stb & ~s_ack_i & (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    cnt_d        = '0;

    case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_d = last_owner_q ? ST_OWN0 : ST_OWN1;
        end else if (m0_cyc_i) begin
          state_d = ST_OWN0;
        end else if (m1_cyc_i) begin
          state_d = ST_OWN1;
        end
      end
      ST_OWN0: begin
        if (!m0_cyc_i) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b0;
        end
      end
      ST_OWN1: begin
        if (!m1_cyc_i) begin
          state_d      = ST_IDLE;
          last_owner_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counter counts cycles of an unanswered strobe; ack or timeout restarts it.
    if (owner_stb && !s_ack_i && !timeout_hit) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
    end
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    if (own0) begin
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
      s_sel_o = m0_sel_i;
      s_we_o  = m0_we_i;
      s_stb_o = m0_stb_i & ~timeout_hit;
      s_cyc_o = m0_cyc_i;
    end else if (own1) begin
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
      s_sel_o = m1_sel_i;
      s_we_o  = m1_we_i;
      s_stb_o = m1_stb_i & ~timeout_hit;
      s_cyc_o = m1_cyc_i;
    end
  end

  assign m0_ack_o = own0 & m0_stb_i & s_ack_i;
  assign m1_ack_o = own1 & m1_stb_i & s_ack_i;
  assign m0_err_o = own0 & timeout_hit;
  assign m1_err_o = own1 & timeout_hit;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign gnt_o    = {own1, own0};

endmodule

// File: tb/tb_wb_arbiter_2.sv
// Self-checking bench for wb_arbiter_2: directed scenarios with literal
// expectations plus a randomized run against an ownership/wait-count model.
module tb_wb_arbiter_2;

  localparam int AW = 36;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic m0_we_i, m0_stb_i, m0_cyc_i, m0_ack_o, m0_err_o;
  logic m1_we_i, m1_stb_i, m1_cyc_i, m1_ack_o, m1_err_o;
  logic s_we_o, s_stb_o, s_cyc_o, s_ack_i;
  logic [1:0] gnt_o;

  wb_arbiter_2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: -1 = nobody; waited = cycles the owner's current strobe went unanswered
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_wait  = 0;

  task automatic check_model();
    logic [1:0]    e_gnt;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic e_we, e_stb, e_cyc, x_stb, err, ack;
    logic e_ack0, e_ack1, e_err0, e_err1;
    e_gnt = 2'b00; e_adr = '0; e_dat = '0; e_sel = '0;
    e_we = 0; e_stb = 0; e_cyc = 0;
    e_ack0 = 0; e_ack1 = 0; e_err0 = 0; e_err1 = 0;
    if (!rst && mdl_owner >= 0) begin
      x_stb = (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
      err   = x_stb && !s_ack_i && (mdl_wait == TO - 1);
      ack   = x_stb && s_ack_i;
      if (mdl_owner == 0) begin
        e_gnt = 2'b01; e_adr = m0_adr_i; e_dat = m0_dat_i; e_sel = m0_sel_i;
        e_we = m0_we_i; e_cyc = m0_cyc_i; e_ack0 = ack; e_err0 = err;
      end else begin
        e_gnt = 2'b10; e_adr = m1_adr_i; e_dat = m1_dat_i; e_sel = m1_sel_i;
        e_we = m1_we_i; e_cyc = m1_cyc_i; e_ack1 = ack; e_err1 = err;
      end
      e_stb = x_stb && !err;
    end
    chk("gnt", 64'(gnt_o), 64'(e_gnt));
    chk("s_adr", 64'(s_adr_o), 64'(e_adr));
    chk("s_dat", 64'(s_dat_o), 64'(e_dat));
    chk("s_sel", 64'(s_sel_o), 64'(e_sel));
    chk("s_we", 64'(s_we_o), 64'(e_we));
    chk("s_stb", 64'(s_stb_o), 64'(e_stb));
    chk("s_cyc", 64'(s_cyc_o), 64'(e_cyc));
    chk("m0_ack", 64'(m0_ack_o), 64'(e_ack0));
    chk("m1_ack", 64'(m1_ack_o), 64'(e_ack1));
    chk("m0_err", 64'(m0_err_o), 64'(e_err0));
    chk("m1_err", 64'(m1_err_o), 64'(e_err1));
    chk("m0_dat_o", 64'(m0_dat_o), 64'(s_dat_i));
    chk("m1_dat_o", 64'(m1_dat_o), 64'(s_dat_i));
  endtask

  task automatic model_edge();
    logic x_cyc, x_stb;
    if (rst) begin
      mdl_owner = -1; mdl_last = 1; mdl_wait = 0;
    end else if (mdl_owner < 0) begin
      mdl_wait = 0;
      if (m0_cyc_i && m1_cyc_i) mdl_owner = (mdl_last == 0) ? 1 : 0;
      else if (m0_cyc_i)        mdl_owner = 0;
      else if (m1_cyc_i)        mdl_owner = 1;
    end else begin
      x_cyc = (mdl_owner == 0) ? m0_cyc_i : m1_cyc_i;
      x_stb = (mdl_owner == 0) ? m0_stb_i : m1_stb_i;
      if (!x_cyc) begin
        mdl_last = mdl_owner; mdl_owner = -1; mdl_wait = 0;
      end else if (s_ack_i || !x_stb || mdl_wait == TO - 1) begin
        mdl_wait = 0;
      end else begin
        mdl_wait++;
      end
    end
  endtask

  // One cycle: compare settled outputs, clock, advance the model.
  task automatic tick();
    #1 check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m0(input logic cyc, input logic stb, input logic [AW-1:0] adr);
    m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr;
  endtask

  task automatic set_m1(input logic cyc, input logic stb, input logic [AW-1:0] adr);
    m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr;
  endtask

  task automatic clear_all();
    set_m0(0, 0, '0); set_m1(0, 0, '0);
    m0_dat_i = '0; m1_dat_i = '0; m0_sel_i = '0; m1_sel_i = '0;
    m0_we_i = 0; m1_we_i = 0; s_ack_i = 0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_all();
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    #1 chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);

    // single m0 read with ack one cycle after the grant
    set_m0(1, 1, 36'h4); m0_sel_i = 4'hF;
    #1 chk("req_gnt_before_edge", 64'(gnt_o), 64'd0);
    tick();
    #1 chk("m0_gnt", 64'(gnt_o), 64'd1);
    chk("m0_s_adr", 64'(s_adr_o), 64'h4);
    s_ack_i = 1; s_dat_i = 32'hCAFE_0004;
    #1 chk("m0_ack", 64'(m0_ack_o), 64'd1);
    chk("m1_ack_quiet", 64'(m1_ack_o), 64'd0);
    chk("m0_rdata", 64'(m0_dat_o), 64'hCAFE_0004);
    tick();
    set_m0(0, 0, '0); s_ack_i = 0;
    #1 chk("m0_ack_once", 64'(m0_ack_o), 64'd0);
    tick();
    #1 chk("idle_after_m0", 64'(gnt_o), 64'd0);
    tick();

    // alternation on ties
    do_reset();
    set_m0(1, 1, 36'h10); set_m1(1, 1, 36'h20);
    tick();
    #1 chk("tie1_m0", 64'(gnt_o), 64'd1);
    set_m0(0, 0, '0);
    tick();
    #1 chk("tie_idle1", 64'(gnt_o), 64'd0);
    tick();
    #1 chk("tie2_m1", 64'(gnt_o), 64'd2);
    set_m1(0, 0, '0); set_m0(1, 1, 36'h10);
    tick();
    set_m1(1, 1, 36'h20);
    #1 chk("tie_idle2", 64'(gnt_o), 64'd0);
    tick();
    #1 chk("tie3_m0", 64'(gnt_o), 64'd1);
    clear_all();
    tick();
    tick();

    // m1 holds cyc across several strobes, m0 must wait
    set_m1(1, 1, 36'h30);
    tick();
    set_m0(1, 1, 36'h40);
    for (int i = 0; i < 6; i++) begin
      m1_stb_i = (i % 2 == 0);
      s_ack_i  = (i % 2 == 0);
      #1 chk("hold_gnt_m1", 64'(gnt_o), 64'd2);
      chk("hold_m0_ack", 64'(m0_ack_o), 64'd0);
      tick();
    end
    s_ack_i = 0;
    set_m1(0, 0, '0);
    tick();
    #1 chk("hold_idle", 64'(gnt_o), 64'd0);
    tick();
    #1 chk("hold_then_m0", 64'(gnt_o), 64'd1);
    clear_all();
    tick();
    tick();

    // slave never answers: err on the eighth owned cycle, then counting restarts
    set_m0(1, 1, 36'h50);
    tick();
    for (int k = 0; k < 10; k++) begin
      #1 chk("to_err", 64'(m0_err_o), 64'(k == 7));
      chk("to_stb", 64'(s_stb_o), 64'(k != 7));
      chk("to_ack", 64'(m0_ack_o), 64'd0);
      tick();
    end
    clear_all();
    tick();
    tick();

    // ack on the threshold cycle wins
    set_m0(1, 1, 36'h60);
    tick();
    for (int k = 0; k < 8; k++) begin
      s_ack_i = (k == 7);
      if (k == 7) begin
        #1 chk("edge_ack", 64'(m0_ack_o), 64'd1);
        chk("edge_err", 64'(m0_err_o), 64'd0);
        chk("edge_stb", 64'(s_stb_o), 64'd1);
      end
      tick();
    end
    clear_all();
    tick();
    tick();

    // reset in the middle of an m1 transfer; late ack discarded
    set_m1(1, 1, 36'h70);
    tick();
    #1 chk("mid_gnt_m1", 64'(gnt_o), 64'd2);
    rst = 1; s_ack_i = 1;
    #1 chk("mid_rst_gnt", 64'(gnt_o), 64'd0);
    chk("mid_rst_cyc", 64'(s_cyc_o), 64'd0);
    tick();
    rst = 0;
    #1 chk("post_rst_gnt", 64'(gnt_o), 64'd0);
    chk("late_ack_m1", 64'(m1_ack_o), 64'd0);
    tick();
    #1 chk("regrant_m1", 64'(gnt_o), 64'd2);
    clear_all();
    tick();
    tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (m0_cyc_i) m0_cyc_i = ($urandom_range(0, 7) != 0);
      else          m0_cyc_i = ($urandom_range(0, 3) == 0);
      if (m1_cyc_i) m1_cyc_i = ($urandom_range(0, 7) != 0);
      else          m1_cyc_i = ($urandom_range(0, 3) == 0);
      m0_stb_i = m0_cyc_i && ($urandom_range(0, 3) != 0);
      m1_stb_i = m1_cyc_i && ($urandom_range(0, 3) != 0);
      m0_adr_i = AW'({$urandom(), $urandom()});
      m1_adr_i = AW'({$urandom(), $urandom()});
      m0_dat_i = $urandom(); m1_dat_i = $urandom();
      m0_sel_i = SW'($urandom()); m1_sel_i = SW'($urandom());
      m0_we_i = 1'($urandom()); m1_we_i = 1'($urandom());
      s_ack_i = ($urandom_range(0, 5) == 0);
      s_dat_i = $urandom();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
